// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multicycle sequencer: state enum, opcodes, Code bit indices.
// ILLEGAL_TRAP_EN adds the TRAP state to the enum.
package rv_ctrl_pkg;

    localparam int CODE_W = 10;

    localparam int CODE_JAL     = 0;
    localparam int CODE_JALR    = 1;
    localparam int CODE_LUI     = 2;
    localparam int CODE_AUIPC   = 3;
    localparam int CODE_BRANCH  = 4;
    localparam int CODE_OP      = 5;
    localparam int CODE_STORE   = 6;
    localparam int CODE_OPIMM   = 7;
    localparam int CODE_LOAD    = 8;
    localparam int CODE_ILLEGAL = 9;

    localparam logic [CODE_W-1:0] CODE_RST = 10'b10_0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
`ifdef ILLEGAL_TRAP_EN
        ,
        ST_TRAP   = 3'd6
`endif
    } state_e;

    // Stores, branches and unrecognised words never write the register file.
    function automatic logic writes_rd(input logic [CODE_W-1:0] code);
        return !(code[CODE_STORE] || code[CODE_BRANCH] || code[CODE_ILLEGAL]);
    endfunction

    function automatic logic is_mem_class(input logic [CODE_W-1:0] code);
        return code[CODE_LOAD] || code[CODE_STORE];
    endfunction

endpackage

// File: rtl/insn_class_dec.sv
// Purely combinational opcode-to-class decoder producing a one-hot Code vector.
// Shared between the sequencer and the instruction decoder.
module insn_class_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        code = '0;
        case (opcode)
            OPC_JAL:    code[CODE_JAL]     = 1'b1;
            OPC_JALR:   code[CODE_JALR]    = 1'b1;
            OPC_LUI:    code[CODE_LUI]     = 1'b1;
            OPC_AUIPC:  code[CODE_AUIPC]   = 1'b1;
            OPC_BRANCH: code[CODE_BRANCH]  = 1'b1;
            OPC_OP:     code[CODE_OP]      = 1'b1;
            OPC_STORE:  code[CODE_STORE]   = 1'b1;
            OPC_OPIMM:  code[CODE_OPIMM]   = 1'b1;
            OPC_LOAD:   code[CODE_LOAD]    = 1'b1;
            default:    code[CODE_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with halt parking.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions enter a sticky TRAP state instead of acting as NOP.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       insn_in,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic [31:0]       INSN,
    output logic [CODE_W-1:0] Code,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              pc_we,
    output logic              rd_we,
    output logic              busy,
    output logic              halted,
    output logic              trap
);

    state_e              state_q, state_d;
    logic [31:0]         insn_q;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   dec_code;

    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q,  dmem_we_d;
    logic pc_we_q,    pc_we_d;
    logic rd_we_q,    rd_we_d;
    logic busy_q,     busy_d;
    logic halted_q,   halted_d;
`ifdef ILLEGAL_TRAP_EN
    logic trap_q,     trap_d;
`endif

    logic fetch_done;

    // imem_req_q gates acceptance so the reset-held FETCH cycle cannot swallow a stray mem_ready.
    assign fetch_done = (state_q == ST_FETCH) && imem_req_q && mem_ready;

    insn_class_dec u_class_dec (
        .opcode (insn_q[6:0]),
        .code   (dec_code)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_FETCH;
            insn_q     <= 32'h0000_0000;
            code_q     <= CODE_RST;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_we_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            if (fetch_done) begin
                insn_q <= insn_in;
            end
            if (state_q == ST_DECODE) begin
                code_q <= dec_code;
            end
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            pc_we_q    <= pc_we_d;
            rd_we_q    <= rd_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
`ifdef ILLEGAL_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_done) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_mem_class(code_q)) begin
                    state_d = ST_MEM;
`ifdef ILLEGAL_TRAP_EN
                end else if (code_q[CODE_ILLEGAL]) begin
                    state_d = ST_TRAP;
`endif
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT: begin
                if (!halt_req) begin
                    state_d = ST_FETCH;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs are computed from the next state and registered, so they line up with state_q.
    always_comb begin
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && code_q[CODE_STORE];
        pc_we_d    = (state_d == ST_WB);
        rd_we_d    = (state_d == ST_WB) && writes_rd(code_q);
        busy_d     = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                     (state_d == ST_EXEC)  || (state_d == ST_MEM)    ||
                     (state_d == ST_WB);
        halted_d   = (state_d == ST_HALT);
`ifdef ILLEGAL_TRAP_EN
        trap_d     = (state_d == ST_TRAP);
`endif
    end

    assign INSN     = insn_q;
    assign Code     = code_q;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign pc_we    = pc_we_q;
    assign rd_we    = rd_we_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
`ifdef ILLEGAL_TRAP_EN
    assign trap     = trap_q;
`else
    assign trap     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: reset, ALU/load/store/branch timing, halt, mid-MEM reset, illegal word.
module tb_multicycle_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] insn_in;
    logic        mem_ready;
    logic        halt_req;
    logic [31:0] INSN;
    logic [9:0]  Code;
    logic        imem_req, dmem_req, dmem_we, pc_we, rd_we, busy, halted, trap;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    multicycle_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .insn_in   (insn_in),
        .mem_ready (mem_ready),
        .halt_req  (halt_req),
        .INSN      (INSN),
        .Code      (Code),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .pc_we     (pc_we),
        .rd_we     (rd_we),
        .busy      (busy),
        .halted    (halted),
        .trap      (trap)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {24'h0, imem_req, dmem_req, dmem_we, pc_we, rd_we, busy, halted, trap};
    endfunction

    // Runs one instruction starting in a FETCH cycle with imem_req already high.
    task automatic do_insn(input string nm, input logic [31:0] word, input int wait_cyc,
                           input logic [9:0] exp_code, input logic exp_we,
                           input logic exp_rd, input logic is_mem);
        int start;
        int lat;
        start = cyc;
        lat   = is_mem ? (5 + wait_cyc) : 4;
        chk({nm, "_fetch_req"}, imem_req, 1);
        insn_in   = word;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk({nm, "_insn"}, INSN, word);
        chk({nm, "_decode_req"}, imem_req, 0);
        step();
        chk({nm, "_code"}, Code, exp_code);
        chk({nm, "_exec_busy"}, busy, 1);
        step();
        if (is_mem) begin
            for (int w = 0; w <= wait_cyc; w++) begin
                chk({nm, "_dmem_req"}, dmem_req, 1);
                chk({nm, "_dmem_we"}, dmem_we, exp_we);
                if (w == wait_cyc) mem_ready = 1'b1;
                step();
                mem_ready = 1'b0;
            end
        end
        chk({nm, "_wb_dmem_req"}, dmem_req, 0);
        chk({nm, "_wb_pc_we"}, pc_we, 1);
        chk({nm, "_wb_rd_we"}, rd_we, exp_rd);
        chk({nm, "_wb_trap"}, trap, 0);
        step();
        chk({nm, "_next_fetch"}, imem_req, 1);
        chk({nm, "_next_pc_we"}, pc_we, 0);
        chk({nm, "_latency"}, cyc - start, lat);
    endtask

    initial begin
        RST_N     = 1'b0;
        insn_in   = 32'h0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        step();
        mem_ready = 1'b1;
        step();
        step();
        chk("rst_strobes", strobes(), 0);
        chk("rst_insn", INSN, 32'h0);
        chk("rst_code", Code, 32'h200);
        mem_ready = 1'b0;
        RST_N     = 1'b1;
        step();
        chk("rel_imem_req", imem_req, 1);
        chk("rel_busy", busy, 1);

        do_insn("addi", 32'h00500093, 0, 10'h080, 1'b0, 1'b1, 1'b0);
        do_insn("lw",   32'h0000A103, 2, 10'h100, 1'b0, 1'b1, 1'b1);
        do_insn("sw",   32'h0020A023, 0, 10'h040, 1'b1, 1'b0, 1'b1);
        do_insn("beq",  32'h00208063, 0, 10'h010, 1'b0, 1'b0, 1'b0);

        // halt_req raised early must not abandon the instruction
        insn_in   = 32'h00500093;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        halt_req  = 1'b1;
        chk("halt_decode_halted", halted, 0);
        step();
        chk("halt_exec_halted", halted, 0);
        step();
        chk("halt_wb_pc_we", pc_we, 1);
        chk("halt_wb_rd_we", rd_we, 1);
        step();
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_imem_req", imem_req, 0);
        step();
        chk("halt_stays", halted, 1);
        halt_req = 1'b0;
        step();
        chk("unhalt_imem_req", imem_req, 1);
        chk("unhalt_halted", halted, 0);

        // Reset asserted in the middle of a load's MEM wait
        insn_in   = 32'h0000A103;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        step();
        chk("mrst_dmem_req_before", dmem_req, 1);
        RST_N = 1'b0;
        #1;
        chk("mrst_dmem_req_drop", dmem_req, 0);
        chk("mrst_strobes", strobes(), 0);
        chk("mrst_insn", INSN, 32'h0);
        chk("mrst_code", Code, 32'h200);
        step();
        RST_N = 1'b1;
        step();
        chk("mrst_rel_imem_req", imem_req, 1);
        chk("mrst_no_retry", dmem_req, 0);

`ifdef ILLEGAL_TRAP_EN
        insn_in   = 32'hFFFFFFFF;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        chk("ill_code", Code, 32'h200);
        step();
        chk("ill_trap", trap, 1);
        chk("ill_pc_we", pc_we, 0);
        chk("ill_rd_we", rd_we, 0);
        chk("ill_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ill_trap_sticky", trap, 1);
            chk("ill_no_pc_we", pc_we, 0);
            chk("ill_no_fetch", imem_req, 0);
        end
`else
        do_insn("ill", 32'hFFFFFFFF, 0, 10'h200, 1'b0, 1'b0, 1'b0);
        chk("ill_trap_tied", trap, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge; all state updates on this edge.
REQ-002 SHALL have ports: RST_N  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: insn_in  in  32  word returned by instruction memory.
REQ-004 SHALL have ports: mem_ready  in  1  memory completion strobe, shared by instruction and data accesses.
REQ-005 SHALL have ports: halt_req  in  1  level request to park the sequencer.
REQ-006 SHALL have ports: INSN  out  32  latched instruction, feeds the instruction decoder.
REQ-007 SHALL have ports: Code  out  10  one-hot class: [0]JAL [1]JALR [2]LUI [3]AUIPC [4]BRANCH [5]OP [6]STORE [7]OP-IMM [8]LOAD [9]illegal.
REQ-008 SHALL have ports: imem_req, dmem_req, dmem_we, pc_we, rd_we, busy, halted, trap  out  1 each  sequencing strobes and status.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
REQ-010 SHALL encode the states in a registered state field; all outputs SHALL be registered or decoded from state and registered data only, with no combinational path from insn_in.
REQ-011 FETCH: SHALL hold imem_req=1 until mem_ready=1; on that edge SHALL latch INSN<=insn_in and go to DECODE.
REQ-012 DECODE: SHALL register Code from INSN[6:0] (opcodes 0000011 LOAD, 0010011 OP-IMM, 0100011 STORE, 0110011 OP, 1100011 BRANCH, 0010111 AUIPC, 0110111 LUI, 1100111 JALR, 1101111 JAL; any other value sets bit 9); exactly one bit of Code SHALL be set; then go to EXEC.
REQ-013 EXEC: SHALL last one cycle; next state SHALL be MEM for LOAD or STORE, TRAP for illegal when ILLEGAL_TRAP_EN is defined, else WB.
REQ-014 MEM: SHALL hold dmem_req=1, with dmem_we=1 only for STORE, until mem_ready=1, then go to WB.
REQ-015 WB: SHALL pulse pc_we=1 for exactly one cycle; rd_we SHALL pulse in the same cycle for every class except STORE, BRANCH and illegal.
REQ-016 WB: next state SHALL be HALT if halt_req=1 that cycle, else FETCH.
REQ-017 Latency SHALL be 4 cycles FETCH-to-FETCH for non-memory instructions and 5 cycles for LOAD/STORE when mem_ready is returned in the first request cycle; each wait cycle SHALL add one cycle.
REQ-018 HALT: SHALL set halted=1 and busy=0; on halt_req=0 SHALL go to FETCH.
REQ-019 halt_req SHALL be ignored in every state except WB and HALT, so an instruction is never abandoned.
REQ-020 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-021 busy SHALL be 1 in FETCH, DECODE, EXEC, MEM and WB.

Reset
REQ-022 RST_N=0 SHALL force, at any time including mid-MEM, state=FETCH, INSN=0x00000000, Code=10'b1000000000, and all 1-bit outputs 0.
REQ-023 imem_req SHALL rise on the first CLK edge after RST_N deasserts.
REQ-024 An aborted memory access SHALL NOT be retried; execution restarts from FETCH.

Configuration
REQ-025 Macro ILLEGAL_TRAP_EN, when defined: an illegal Code SHALL enter TRAP, set trap=1 sticky until reset, and SHALL NOT pulse pc_we or rd_we.
REQ-026 Macro ILLEGAL_TRAP_EN, when undefined: an illegal Code SHALL be a NOP (WB with pc_we=1, rd_we=0); the TRAP state SHALL be absent and trap SHALL be tied 0.

Structure
REQ-027 Shared package rv_ctrl_pkg SHALL hold the state enum, the 7-bit opcode constants and the Code bit-index constants.
REQ-028 Opcode-to-Code mapping SHALL be a separate combinational sub-module insn_class_dec, reusable by the decoder.

Verification
REQ-029 Bench SHALL cover: ADDI 0x00500093, mem_ready=1 immediately -> Code=0x080; pc_we and rd_we pulse on cycle 4; FETCH re-entered on cycle 5.
REQ-030 Bench SHALL cover: LW 0x0000A103, data mem_ready delayed 2 cycles -> dmem_req high 3 cycles with dmem_we=0; rd_we pulses; 7-cycle instruction.
REQ-031 Bench SHALL cover: SW 0x0020A023 and BEQ 0x00208063 -> dmem_we=1 for SW only; rd_we=0 and pc_we=1 for both.
REQ-032 Bench SHALL cover: 0xFFFFFFFF -> Code=0x200; with macro defined trap=1 and no pc_we thereafter; without macro a NOP followed by the next fetch.
REQ-033 Bench SHALL cover: RST_N low during MEM of LW -> dmem_req drops immediately; all outputs at reset values; imem_req on the first edge after release.
REQ-034 Bench SHALL cover: halt_req=1 during EXEC -> the instruction completes WB, then halted=1; halt_req=0 -> imem_req on the next cycle.
